// File: rtl/femto_hs_pkg.sv
// femto_hs_pkg -- shared definitions for the toggle handshake responder.
//   hs_state_t   : responder FSM encoding (IDLE = 0, HOLD = 1)
//   SYNC_STAGES  : depth of the optional request synchroniser
//   DATA_W_DEF   : default payload width
//   CNT_W_DEF    : default completed-transfer counter width
package femto_hs_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hs_state_t;

endpackage

// File: rtl/toggle_detect.sv
// toggle_detect -- turns a toggling request level into a one-cycle event.
// Optional macro TOGGLE_SYNC_EN inserts a SYNC_STAGES-flop synchroniser in
// front of the edge detector.
// Ports:
//   clk     in  single clock
//   rst     in  synchronous active-high reset
//   req_tgl in  initiator request level
//   evt     out high while the (synchronised) level differs from req_prev
module toggle_detect
  import femto_hs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_tgl,
  output logic evt
);

  logic req_s;
  logic req_prev;

`ifdef TOGGLE_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
  end

  assign req_s = sync_q[SYNC_STAGES-1];
`else
  assign req_s = req_tgl;
`endif

  // Every event is consumed in the cycle it is seen (captured in IDLE,
  // absorbed as an error in HOLD), so req_prev simply follows req_s.
  always_ff @(posedge clk) begin
    if (rst) req_prev <= 1'b0;
    else     req_prev <= req_s;
  end

  assign evt = req_s ^ req_prev;

endmodule

// File: rtl/toggle_req_responder.sv
// toggle_req_responder -- responder side of a toggle (2-phase) handshake.
// Each req_tgl toggle captures req_data into out_data; the word is offered
// on out_valid until out_ready, at which point ack_tgl toggles and xfer_cnt
// increments. A toggle arriving while a word is pending sets sticky proto_err
// and its payload is discarded.
// Optional macro TOGGLE_SYNC_EN: synchronise req_tgl (2 extra cycles latency).
// Ports:
//   clk       in   single clock
//   rst       in   synchronous active-high reset
//   req_tgl   in   request level, one request per toggle
//   req_data  in   [DATA_W] request payload
//   ack_tgl   out  acknowledge level, toggles per completed transfer
//   out_valid out  out_data holds an unconsumed word
//   out_data  out  [DATA_W] captured payload
//   out_ready in   downstream accepts when high with out_valid
//   proto_err out  sticky protocol violation flag
//   xfer_cnt  out  [CNT_W] completed-transfer count (wraps)
module toggle_req_responder
  import femto_hs_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              proto_err,
  output logic [CNT_W-1:0]  xfer_cnt
);

  hs_state_t         state_q, state_d;
  logic [DATA_W-1:0] data_d;
  logic              ack_d;
  logic              err_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              evt;

  toggle_detect u_detect (
    .clk     (clk),
    .rst     (rst),
    .req_tgl (req_tgl),
    .evt     (evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_data  <= '0;
      ack_tgl   <= 1'b0;
      proto_err <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      out_data  <= data_d;
      ack_tgl   <= ack_d;
      proto_err <= err_d;
      xfer_cnt  <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = out_data;
    ack_d   = ack_tgl;
    err_d   = proto_err;
    cnt_d   = xfer_cnt;
    unique case (state_q)
      IDLE: begin
        if (evt) begin
          data_d  = req_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A toggle while pending is flagged even if the word completes now;
        // its payload is never captured.
        if (evt) err_d = 1'b1;
        if (out_ready) begin
          ack_d   = ~ack_tgl;
          cnt_d   = xfer_cnt + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == HOLD);

endmodule
